// File: rtl/sfx_voice_sched.sv
// sfx_voice_sched: voice allocator, shared sample-ROM fetch and stereo mixer.
// Build option SFX_VOICE_STEAL_EN: a full voice table steals the shortest voice.
module sfx_voice_sched #(
    parameter int NVOICES = 4,
    parameter int ADDR_W  = 16
) (
    input  logic               clk_12,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [ADDR_W-1:0]  req_len,
    input  logic [1:0]         req_vol,
    input  logic [1:0]         req_pan,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    output logic [15:0]        dac_data_l,
    output logic [15:0]        dac_data_r,
    output logic               mix_valid,
    output logic [NVOICES-1:0] voice_busy,
    output logic               done,
    output logic               overrun
);

    localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int AW = 16 + $clog2(NVOICES) + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH    = 2'd1;
    localparam logic [1:0] ACC_LAST = 2'd2;
    localparam logic [1:0] SAT      = 2'd3;

    localparam logic [IW-1:0]        LAST = IW'(NVOICES - 1);
    localparam logic signed [AW-1:0] PMAX = AW'(32767);
    localparam logic signed [AW-1:0] NMIN = AW'(-32768);

    logic [1:0]         state;
    logic [IW-1:0]      idx;
    logic [ADDR_W-1:0]  ptr [NVOICES];
    logic [ADDR_W-1:0]  rem [NVOICES];
    logic [1:0]         vol [NVOICES];
    logic [1:0]         pan [NVOICES];
    logic [NVOICES-1:0] active;
    logic [NVOICES-1:0] fresh;

    logic               hit_q;
    logic [1:0]         vol_q;
    logic [1:0]         pan_q;
    logic signed [AW-1:0] acc_l;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] samp;
    logic signed [AW-1:0] term;

    logic               free_any;
    logic [IW-1:0]      free_idx;
    logic               fetch_hit;

    logic               ld_en;
    logic [IW-1:0]      ld_idx;
    logic [ADDR_W-1:0]  ld_addr;
    logic [ADDR_W-1:0]  ld_len;
    logic [1:0]         ld_vol;
    logic [1:0]         ld_pan;

    function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
        if (a > PMAX) return 16'h7fff;
        if (a < NMIN) return 16'h8000;
        return a[15:0];
    endfunction

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int v = NVOICES - 1; v >= 0; v--) begin
            if (!active[v]) begin
                free_any = 1'b1;
                free_idx = IW'(v);
            end
        end
    end

    // Voices loaded mid-frame stay fresh until IDLE, so they wait a frame.
    assign fetch_hit  = (state == FETCH) && active[idx] && !fresh[idx];
    assign rom_en     = fetch_hit;
    assign rom_addr   = fetch_hit ? ptr[idx] : '0;
    assign voice_busy = active;

`ifdef SFX_VOICE_STEAL_EN
    logic              pend_v;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] pend_len;
    logic [1:0]        pend_vol;
    logic [1:0]        pend_pan;
    logic [IW-1:0]     victim;
    logic [ADDR_W-1:0] best;
    logic              req_live;
    logic              take_new;
    logic              park;
    logic              apply_pend;

    always_comb begin
        victim = '0;
        best   = rem[0];
        for (int v = 1; v < NVOICES; v++) begin
            if (rem[v] < best) begin
                best   = rem[v];
                victim = IW'(v);
            end
        end
    end

    // Steals only land in IDLE; during a frame they wait in one pending slot.
    assign req_ready  = 1'b1;
    assign req_live   = req_valid && (req_len != '0);
    assign take_new   = req_live && (free_any || (state == IDLE && !pend_v));
    assign park       = req_live && !take_new;
    assign apply_pend = pend_v && (state == IDLE) && !req_live;
    assign ld_en      = take_new || apply_pend;
    assign ld_idx     = free_any ? free_idx : victim;
    assign ld_addr    = take_new ? req_addr : pend_addr;
    assign ld_len     = take_new ? req_len : pend_len;
    assign ld_vol     = take_new ? req_vol : pend_vol;
    assign ld_pan     = take_new ? req_pan : pend_pan;

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_len  <= '0;
            pend_vol  <= '0;
            pend_pan  <= '0;
        end else if (park) begin
            pend_v    <= 1'b1;
            pend_addr <= req_addr;
            pend_len  <= req_len;
            pend_vol  <= req_vol;
            pend_pan  <= req_pan;
        end else if (apply_pend) begin
            pend_v    <= 1'b0;
        end
    end
`else
    assign req_ready = free_any;
    assign ld_en     = req_valid && free_any && (req_len != '0);
    assign ld_idx    = free_idx;
    assign ld_addr   = req_addr;
    assign ld_len    = req_len;
    assign ld_vol    = req_vol;
    assign ld_pan    = req_pan;
`endif

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            active <= '0;
            fresh  <= '0;
            for (int v = 0; v < NVOICES; v++) begin
                ptr[v] <= '0;
                rem[v] <= '0;
                vol[v] <= '0;
                pan[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NVOICES; v++) begin
                if (ld_en && ld_idx == IW'(v)) begin
                    ptr[v]    <= ld_addr;
                    rem[v]    <= ld_len;
                    vol[v]    <= ld_vol;
                    pan[v]    <= ld_pan;
                    active[v] <= 1'b1;
                    fresh[v]  <= (state != IDLE);
                end else if (fetch_hit && idx == IW'(v)) begin
                    ptr[v] <= ptr[v] + ADDR_W'(1);
                    rem[v] <= rem[v] - ADDR_W'(1);
                    if (rem[v] == ADDR_W'(1)) active[v] <= 1'b0;
                end else if (state == IDLE) begin
                    fresh[v] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        samp = AW'($signed(rom_data));
        term = samp >>> vol_q;
    end

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            hit_q      <= 1'b0;
            vol_q      <= '0;
            pan_q      <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            dac_data_l <= '0;
            dac_data_r <= '0;
            mix_valid  <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            hit_q     <= fetch_hit;
            vol_q     <= vol[idx];
            pan_q     <= pan[idx];
            done      <= fetch_hit && (rem[idx] == ADDR_W'(1));
            mix_valid <= (state == SAT);
            if (frame_start && state != IDLE) overrun <= 1'b1;
            if (hit_q) begin
                if (pan_q != 2'b10) acc_l <= acc_l + term;
                if (pan_q != 2'b01) acc_r <= acc_r + term;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (idx == LAST) state <= ACC_LAST;
                    else idx <= idx + IW'(1);
                end
                ACC_LAST: state <= SAT;
                default: begin
                    dac_data_l <= sat16(acc_l);
                    dac_data_r <= sat16(acc_r);
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_voice_sched.sv
// tb_sfx_voice_sched: random and directed play requests against a frame-level
// model of voice allocation, ROM fetch order and the saturating stereo mix.
module tb_sfx_voice_sched;

    localparam int NV = 4;
    localparam int AW = 16;

    logic          clk_12 = 1'b0;
    logic          reset_n;
    logic          frame_start;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic [1:0]    req_vol;
    logic [1:0]    req_pan;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data = '0;
    logic [15:0]   dac_data_l;
    logic [15:0]   dac_data_r;
    logic          mix_valid;
    logic [NV-1:0] voice_busy;
    logic          done;
    logic          overrun;

    sfx_voice_sched #(.NVOICES(NV), .ADDR_W(AW)) dut (
        .clk_12     (clk_12),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_vol    (req_vol),
        .req_pan    (req_pan),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dac_data_l (dac_data_l),
        .dac_data_r (dac_data_r),
        .mix_valid  (mix_valid),
        .voice_busy (voice_busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #41 clk_12 = ~clk_12;

    logic signed [15:0] rom_mem [0:65535];

    always @(posedge clk_12) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    bit m_act [NV];
    int m_ptr [NV];
    int m_rem [NV];
    int m_vol [NV];
    int m_pan [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag,
                     $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int v = 0; v < NV; v++) b[v] = m_act[v];
        return b;
    endfunction

    task automatic post_req(input int a, input int len, input int vol,
                            input int pan);
        bit exp_rdy = 1'b0;
        int slot = -1;
        for (int v = NV - 1; v >= 0; v--) begin
            if (!m_act[v]) begin
                exp_rdy = 1'b1;
                slot = v;
            end
        end
        @(negedge clk_12);
        req_valid = 1'b1;
        req_addr  = a[AW-1:0];
        req_len   = len[AW-1:0];
        req_vol   = vol[1:0];
        req_pan   = pan[1:0];
        #1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk_12);
        #1;
        req_valid = 1'b0;
        if (exp_rdy && len != 0) begin
            m_act[slot] = 1'b1;
            m_ptr[slot] = a;
            m_rem[slot] = len;
            m_vol[slot] = vol;
            m_pan[slot] = pan;
        end
    endtask

    // One frame: every active voice reads one sample in slot order.
    task automatic run_frame(input bit inj);
        bit e_en   [NV+4];
        int e_addr [NV+4];
        bit e_done [NV+4];
        int al = 0;
        int ar = 0;
        int s;
        for (int k = 0; k < NV + 4; k++) begin
            e_en[k] = 1'b0;
            e_addr[k] = 0;
            e_done[k] = 1'b0;
        end
        for (int i = 0; i < NV; i++) begin
            if (m_act[i]) begin
                e_en[i+1] = 1'b1;
                e_addr[i+1] = m_ptr[i];
                s = rom_mem[m_ptr[i]];
                s = s >>> m_vol[i];
                if (m_pan[i] != 2) al += s;
                if (m_pan[i] != 1) ar += s;
                m_ptr[i] = (m_ptr[i] + 1) % 65536;
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_act[i] = 1'b0;
                    e_done[i+2] = 1'b1;
                end
            end
        end
        al = (al > 32767) ? 32767 : (al < -32768) ? -32768 : al;
        ar = (ar > 32767) ? 32767 : (ar < -32768) ? -32768 : ar;
        @(negedge clk_12);
        frame_start = 1'b1;
        for (int k = 1; k <= NV + 3; k++) begin
            @(negedge clk_12);
            frame_start = 1'b0;
            chk("rom_en", 32'(rom_en), 32'(e_en[k]));
            if (e_en[k]) chk("rom_addr", 32'(rom_addr), e_addr[k]);
            chk("done", 32'(done), 32'(e_done[k]));
            chk("mix_valid", 32'(mix_valid), 32'(k == NV + 3));
            if (inj && k == 2) frame_start = 1'b1;
        end
        chk("dac_l", 32'($signed(dac_data_l)), al);
        chk("dac_r", 32'($signed(dac_data_r)), ar);
        chk("voice_busy", 32'(voice_busy), model_busy());
        if (inj) chk("overrun_set", 32'(overrun), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_12);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom_mem[a] = 16'($urandom_range(0, 65535));
        for (int v = 0; v < NV; v++) m_act[v] = 1'b0;
        reset_n = 1'b0;
        frame_start = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_len = '0;
        req_vol = '0;
        req_pan = '0;
        idle(3);
        chk("rst_dac_l", 32'(dac_data_l), 32'd0);
        chk("rst_dac_r", 32'(dac_data_r), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_mix_valid", 32'(mix_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(voice_busy), 32'd0);
        reset_n = 1'b1;
        idle(2);

        run_frame(1'b0);

        rom_mem[16'h0100] = 16'sd1000;
        rom_mem[16'h0101] = 16'sd1000;
        rom_mem[16'h0102] = 16'sd1000;
        post_req(16'h0100, 3, 0, 0);
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b0);
            idle(2);
        end

        rom_mem[16'h2000] = 16'sd30000;
        rom_mem[16'h2001] = 16'sd30000;
        post_req(16'h2000, 1, 0, 0);
        post_req(16'h2001, 1, 0, 0);
        run_frame(1'b0);
        chk("sat_pos", 32'($signed(dac_data_l)), 32'd32767);
        rom_mem[16'h2000] = -16'sd30000;
        rom_mem[16'h2001] = -16'sd30000;
        post_req(16'h2000, 1, 0, 3);
        post_req(16'h2001, 1, 0, 3);
        run_frame(1'b0);
        chk("sat_neg", 32'($signed(dac_data_r)), -32'sd32768);

        rom_mem[16'h3000] = 16'sd800;
        rom_mem[16'h3100] = -16'sd800;
        post_req(16'h3000, 1, 1, 1);
        post_req(16'h3100, 1, 2, 2);
        run_frame(1'b0);
        chk("pan_l", 32'($signed(dac_data_l)), 32'd400);
        chk("pan_r", 32'($signed(dac_data_r)), -32'sd200);

        post_req(16'hfffe, 4, 0, 0);
        post_req(16'h0000, 0, 0, 0);
        for (int f = 0; f < 4; f++) run_frame(1'b0);

        for (int v = 0; v < NV; v++) post_req($urandom_range(0, 65535), 10, 1, 0);
        post_req(16'h4000, 2, 0, 0);
        chk("full_busy", 32'(voice_busy), 32'hf);
        run_frame(1'b1);
        idle(2);
        run_frame(1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        for (int it = 0; it < 40; it++) begin
            int nreq = $urandom_range(0, 2);
            for (int r = 0; r < nreq; r++)
                post_req($urandom_range(0, 65535), $urandom_range(0, 6),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            idle($urandom_range(0, 3));
            run_frame(1'b0);
        end

        for (int v = 0; v < NV; v++) begin
            if (!m_act[v]) post_req($urandom_range(0, 65535), 20, 0, 0);
        end
        run_frame(1'b0);
        @(negedge clk_12);
        frame_start = 1'b1;
        @(negedge clk_12);
        frame_start = 1'b0;
        @(negedge clk_12);
        reset_n = 1'b0;
        #1;
        for (int v = 0; v < NV; v++) m_act[v] = 1'b0;
        chk("mid_rst_dac_l", 32'(dac_data_l), 32'd0);
        chk("mid_rst_dac_r", 32'(dac_data_r), 32'd0);
        chk("mid_rst_rom_en", 32'(rom_en), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_busy", 32'(voice_busy), model_busy());
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        idle(2);
        reset_n = 1'b1;
        for (int k = 0; k < NV + 4; k++) begin
            @(negedge clk_12);
            chk("post_rst_mix", 32'(mix_valid), 32'd0);
        end
        run_frame(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
